// File: rtl/hazard_ctrl_if.sv
// Bundle of the hazard sequencer's pipeline-facing signals.
// Latency: none (wires only).
// Backpressure: carries the stall/flush controls that back-pressure the pipeline.
//
// Modports:
//   master - hazard_ctrl side: samples hazard sources, drives stall/flush/status.
//   slave  - pipeline side: drives hazard sources, consumes stall/flush/status.
interface hazard_ctrl_if;
    // hazard sources
    logic [4:0] id_rs1_addr_i;
    logic [4:0] id_rs2_addr_i;
    logic       id_rs1_re_i;
    logic       id_rs2_re_i;
    logic [4:0] exe_rdaddr_i;
    logic       exe_rdwe_i;
    logic       exe_memrd_i;
    logic       exe_md_start_i;
    logic       md_done_i;
    logic       exe_jump_i;
    logic       trap_i;
    logic       mem_busy_i;
    // pipeline controls and status
    logic       stall_pc_o;
    logic       stall_ifid_o;
    logic       stall_idexe_o;
    logic       stall_exemem_o;
    logic       flush_ifid_o;
    logic       flush_idexe_o;
    logic       flush_exemem_o;
    logic       flush_memwb_o;
    logic       md_timeout_o;
    logic [1:0] state_o;

    modport master (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
               exe_rdaddr_i, exe_rdwe_i, exe_memrd_i, exe_md_start_i,
               md_done_i, exe_jump_i, trap_i, mem_busy_i,
        output stall_pc_o, stall_ifid_o, stall_idexe_o, stall_exemem_o,
               flush_ifid_o, flush_idexe_o, flush_exemem_o, flush_memwb_o,
               md_timeout_o, state_o
    );

    modport slave (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i, id_rs2_re_i,
               exe_rdaddr_i, exe_rdwe_i, exe_memrd_i, exe_md_start_i,
               md_done_i, exe_jump_i, trap_i, mem_busy_i,
        input  stall_pc_o, stall_ifid_o, stall_idexe_o, stall_exemem_o,
               flush_ifid_o, flush_idexe_o, flush_exemem_o, flush_memwb_o,
               md_timeout_o, state_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32IM core: per-stage stall/flush and PC hold.
// Latency: controls are combinational from registered state + current inputs; state updates on posedge clk.
// Backpressure: trap > data-bus wait > MUL/DIV wait > jump > load-use; stalls hold stages, flushes insert bubbles.
//
// Ports:
//   clk, rst  - core clock, synchronous active-high reset (forces all outputs to 0)
//   hz        - hazard_ctrl_if.master: hazard sources in, stall/flush/timeout/state out
//   perf_*_o  - 32-bit cycle counters per top-priority stall cause (only with HAZARD_PERF_EN)
// Optional feature macro: HAZARD_PERF_EN
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64   // 2..255 cycles in MD_WAIT before abort
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   perf_lu_cnt_o,
    output logic [31:0]   perf_md_cnt_o,
    output logic [31:0]   perf_bus_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_BUS_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] MD_CNT_LAST = 8'(MD_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic       jmp_pend_q, jmp_pend_d;

    logic lu;        // load-use hazard between EXE load and ID consumer
    logic md_act;    // MUL/DIV in flight and not finishing this cycle
    logic md_tmo;    // last allowed MD_WAIT cycle
    logic jump_eff;  // jump present now or deferred from an earlier stall

    logic s_pc, s_ifid, s_idexe, s_exemem;
    logic f_ifid, f_idexe, f_exemem, f_memwb;
    logic tmo;

    assign lu = hz.exe_memrd_i & hz.exe_rdwe_i & (hz.exe_rdaddr_i != 5'd0) &
                ((hz.id_rs1_re_i & (hz.id_rs1_addr_i == hz.exe_rdaddr_i)) |
                 (hz.id_rs2_re_i & (hz.id_rs2_addr_i == hz.exe_rdaddr_i)));

    // A start seen outside MD_WAIT (RUN, or BUS_WAIT once the bus has released)
    // begins a wait; a done in the same cycle means a single-cycle op, no stall.
    assign md_act   = ~hz.md_done_i & ((state_q == ST_MD_WAIT) | hz.exe_md_start_i);
    assign md_tmo   = (state_q == ST_MD_WAIT) & (md_cnt_q == MD_CNT_LAST);
    assign jump_eff = hz.exe_jump_i | jmp_pend_q;

    always_comb begin
        s_pc       = 1'b0;
        s_ifid     = 1'b0;
        s_idexe    = 1'b0;
        s_exemem   = 1'b0;
        f_ifid     = 1'b0;
        f_idexe    = 1'b0;
        f_exemem   = 1'b0;
        f_memwb    = 1'b0;
        tmo        = 1'b0;
        state_d    = ST_RUN;
        md_cnt_d   = 8'd0;
        jmp_pend_d = jmp_pend_q;

        if (hz.trap_i) begin
            // Trap squashes everything younger than MEM, including a pending jump.
            f_ifid     = 1'b1;
            f_idexe    = 1'b1;
            f_exemem   = 1'b1;
            jmp_pend_d = 1'b0;
        end else if (hz.mem_busy_i) begin
            s_pc       = 1'b1;
            s_ifid     = 1'b1;
            s_idexe    = 1'b1;
            s_exemem   = 1'b1;
            f_memwb    = 1'b1;
            state_d    = ST_BUS_WAIT;
            jmp_pend_d = jmp_pend_q | hz.exe_jump_i;
        end else if (md_act) begin
            s_pc       = 1'b1;
            s_ifid     = 1'b1;
            s_idexe    = 1'b1;
            f_exemem   = 1'b1;
            jmp_pend_d = jmp_pend_q | hz.exe_jump_i;
            if (md_tmo) begin
                tmo     = 1'b1;
                state_d = ST_RUN;
            end else begin
                state_d  = ST_MD_WAIT;
                // count restarts at 0 on the first MD_WAIT cycle
                md_cnt_d = (state_q == ST_MD_WAIT) ? md_cnt_q + 8'd1 : 8'd0;
            end
        end else if (jump_eff) begin
            f_ifid     = 1'b1;
            f_idexe    = 1'b1;
            jmp_pend_d = 1'b0;
        end else if (lu) begin
            s_pc    = 1'b1;
            s_ifid  = 1'b1;
            f_idexe = 1'b1;
        end
    end

    // Reset forces every output low; a flush wins over a stall on the same stage.
    assign hz.stall_pc_o     = ~rst & s_pc;
    assign hz.stall_ifid_o   = ~rst & s_ifid   & ~f_ifid;
    assign hz.stall_idexe_o  = ~rst & s_idexe  & ~f_idexe;
    assign hz.stall_exemem_o = ~rst & s_exemem & ~f_exemem;
    assign hz.flush_ifid_o   = ~rst & f_ifid;
    assign hz.flush_idexe_o  = ~rst & f_idexe;
    assign hz.flush_exemem_o = ~rst & f_exemem;
    assign hz.flush_memwb_o  = ~rst & f_memwb;
    assign hz.md_timeout_o   = ~rst & tmo;
    assign hz.state_o        = rst ? 2'd0 : state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            md_cnt_q   <= 8'd0;
            jmp_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            md_cnt_q   <= md_cnt_d;
            jmp_pend_q <= jmp_pend_d;
        end
    end

`ifdef HAZARD_PERF_EN
    // Only the highest-priority active cause is charged for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_cnt_o  <= 32'd0;
            perf_md_cnt_o  <= 32'd0;
            perf_bus_cnt_o <= 32'd0;
        end else begin
            if (~hz.trap_i & hz.mem_busy_i)
                perf_bus_cnt_o <= perf_bus_cnt_o + 32'd1;
            if (~hz.trap_i & ~hz.mem_busy_i & md_act)
                perf_md_cnt_o <= perf_md_cnt_o + 32'd1;
            if (~hz.trap_i & ~hz.mem_busy_i & ~md_act & ~jump_eff & lu)
                perf_lu_cnt_o <= perf_lu_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (MD_TIMEOUT 64 and 8) share stimulus.
// Directed scenarios followed by random traffic, every cycle compared to a behavioural model.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_re, rs2_re, rdwe, memrd, md_start, md_done, jump, trap, busy;

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();

    assign ifa.id_rs1_addr_i  = rs1;      assign ifb.id_rs1_addr_i  = rs1;
    assign ifa.id_rs2_addr_i  = rs2;      assign ifb.id_rs2_addr_i  = rs2;
    assign ifa.id_rs1_re_i    = rs1_re;   assign ifb.id_rs1_re_i    = rs1_re;
    assign ifa.id_rs2_re_i    = rs2_re;   assign ifb.id_rs2_re_i    = rs2_re;
    assign ifa.exe_rdaddr_i   = rd;       assign ifb.exe_rdaddr_i   = rd;
    assign ifa.exe_rdwe_i     = rdwe;     assign ifb.exe_rdwe_i     = rdwe;
    assign ifa.exe_memrd_i    = memrd;    assign ifb.exe_memrd_i    = memrd;
    assign ifa.exe_md_start_i = md_start; assign ifb.exe_md_start_i = md_start;
    assign ifa.md_done_i      = md_done;  assign ifb.md_done_i      = md_done;
    assign ifa.exe_jump_i     = jump;     assign ifb.exe_jump_i     = jump;
    assign ifa.trap_i         = trap;     assign ifb.trap_i         = trap;
    assign ifa.mem_busy_i     = busy;     assign ifb.mem_busy_i     = busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] pa_lu, pa_md, pa_bus, pb_lu, pb_md, pb_bus;
`endif

    hazard_ctrl #(.MD_TIMEOUT(64)) dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (ifa)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_cnt_o  (pa_lu),
        .perf_md_cnt_o  (pa_md),
        .perf_bus_cnt_o (pa_bus)
`endif
    );

    hazard_ctrl #(.MD_TIMEOUT(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (ifb)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_cnt_o  (pb_lu),
        .perf_md_cnt_o  (pb_md),
        .perf_bus_cnt_o (pb_bus)
`endif
    );

    // {stall pc,ifid,idexe,exemem, flush ifid,idexe,exemem,memwb, md_timeout, state[1:0]}
    logic [10:0] obs_a, obs_b;
    assign obs_a = {ifa.stall_pc_o, ifa.stall_ifid_o, ifa.stall_idexe_o, ifa.stall_exemem_o,
                    ifa.flush_ifid_o, ifa.flush_idexe_o, ifa.flush_exemem_o, ifa.flush_memwb_o,
                    ifa.md_timeout_o, ifa.state_o};
    assign obs_b = {ifb.stall_pc_o, ifb.stall_ifid_o, ifb.stall_idexe_o, ifb.stall_exemem_o,
                    ifb.flush_ifid_o, ifb.flush_idexe_o, ifb.flush_exemem_o, ifb.flush_memwb_o,
                    ifb.md_timeout_o, ifb.state_o};

    int n_assert = 0;
    int n_fail   = 0;
    int n_pc_a, n_memwb_a, n_to_b;
    logic [10:0] last_a;

    // Reference model: mode 0 running, 1 waiting on MUL/DIV, 2 waiting on the data bus.
    int   m_mode [2];
    int   m_wait [2];   // MUL/DIV wait cycles already completed
    bit   m_pend [2];   // jump deferred behind a stall
    logic [31:0] m_plu, m_pmd, m_pbus;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int k, output logic [10:0] e);
        int limit;
        bit lu, md;
        limit = (k == 0) ? 64 : 8;
        e = '0;
        if (rst) begin
            m_mode[k] = 0; m_wait[k] = 0; m_pend[k] = 0;
            if (k == 0) begin m_plu = 0; m_pmd = 0; m_pbus = 0; end
            return;
        end
        e[1:0] = 2'(m_mode[k]);
        lu = memrd && rdwe && (rd != 0) &&
             ((rs1_re && rs1 == rd) || (rs2_re && rs2 == rd));
        md = !md_done && (m_mode[k] == 1 || md_start);
        if (trap) begin
            e[6:4] = 3'b111;
            m_mode[k] = 0; m_wait[k] = 0; m_pend[k] = 0;
        end else if (busy) begin
            e[10:7] = 4'hf; e[3] = 1'b1;
            m_mode[k] = 2; m_wait[k] = 0; m_pend[k] = m_pend[k] | jump;
            if (k == 0) m_pbus++;
        end else if (md) begin
            e[10:8] = 3'b111; e[4] = 1'b1;
            m_pend[k] = m_pend[k] | jump;
            if (k == 0) m_pmd++;
            if (m_mode[k] == 1 && m_wait[k] == limit - 1) begin
                e[2] = 1'b1; m_mode[k] = 0; m_wait[k] = 0;
            end else begin
                m_wait[k] = (m_mode[k] == 1) ? m_wait[k] + 1 : 0;
                m_mode[k] = 1;
            end
        end else if (jump || m_pend[k]) begin
            e[6:5] = 2'b11;
            m_mode[k] = 0; m_wait[k] = 0; m_pend[k] = 0;
        end else if (lu) begin
            e[10:9] = 2'b11; e[5] = 1'b1;
            m_mode[k] = 0; m_wait[k] = 0;
            if (k == 0) m_plu++;
        end else begin
            m_mode[k] = 0; m_wait[k] = 0;
        end
    endtask

    task automatic step(input string tag);
        logic [10:0] ea, eb;
        @(negedge clk);
`ifdef HAZARD_PERF_EN
        chk({tag, "/perf_lu"},  pa_lu,  m_plu);
        chk({tag, "/perf_md"},  pa_md,  m_pmd);
        chk({tag, "/perf_bus"}, pa_bus, m_pbus);
`endif
        model(0, ea);
        model(1, eb);
        chk({tag, "/a"}, {21'd0, obs_a}, {21'd0, ea});
        chk({tag, "/b"}, {21'd0, obs_b}, {21'd0, eb});
        last_a = obs_a;
        if (obs_a[10]) n_pc_a++;
        if (obs_a[3])  n_memwb_a++;
        if (obs_b[2])  n_to_b++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rs1 = 0; rs2 = 0; rd = 0; rs1_re = 0; rs2_re = 0; rdwe = 0; memrd = 0;
        md_start = 0; md_done = 0; jump = 0; trap = 0; busy = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin m_mode[k] = 0; m_wait[k] = 0; m_pend[k] = 0; end
        m_plu = 0; m_pmd = 0; m_pbus = 0;
        clear_in();
        rst = 1'b1;
        @(posedge clk); #1;

        // reset: hazard sources active, yet every output must stay low
        busy = 1; md_start = 1; jump = 1; memrd = 1; rdwe = 1; rd = 2; rs1 = 2; rs1_re = 1;
        repeat (3) step("reset");
        chk("reset_outputs", {21'd0, last_a}, 32'd0);
        rst = 1'b0;
        clear_in();
        step("idle");

        // load-use: lw x5 in EXE, add x6,x5,x1 in ID
        memrd = 1; rdwe = 1; rd = 5; rs1 = 5; rs1_re = 1; rs2 = 1; rs2_re = 1;
        step("lu");
        chk("lu_ctrl", {21'd0, last_a}, {21'd0, 11'b110_0010_0000});
        memrd = 0; rdwe = 0;
        step("lu_after");
        memrd = 1; rdwe = 1; rd = 0; rs1 = 0;
        step("lu_x0");
        chk("lu_x0_nostall", {31'd0, last_a[10]}, 32'd0);
        rd = 7; rs1 = 3; rs2 = 7; rs2_re = 1;
        step("lu_rs2");
        rs2_re = 0;
        step("lu_no_read");
        clear_in();

        // MUL/DIV finishing 33 cycles after start
        n_pc_a = 0;
        md_start = 1; step("md_start");
        md_start = 0;
        repeat (32) step("md_wait");
        md_done = 1; step("md_done");
        md_done = 0;
        chk("md33_stall_cycles", n_pc_a, 33);
        step("md_after");

        // single-cycle MUL: done in the start cycle
        md_start = 1; md_done = 1; step("md_single");
        chk("md_single_nostall", {21'd0, last_a}, 32'd0);
        clear_in();

        // timeout on the MD_TIMEOUT=8 instance
        n_to_b = 0;
        md_start = 1; step("to_start");
        md_start = 0;
        repeat (7) step("to_wait");
        chk("to_not_yet", n_to_b, 0);
        step("to_fire");
        chk("to_pulse", n_to_b, 1);
        chk("to_state_run", {30'd0, ifb.state_o}, 32'd0);
        repeat (3) step("to_after");
        chk("to_single_pulse", n_to_b, 1);
        md_done = 1; step("to_release_a");
        md_done = 0;

        // bus wait with a jump in EXE: jump applied after release
        n_memwb_a = 0;
        busy = 1; jump = 1;
        repeat (3) step("bus");
        busy = 0;
        step("bus_jump");
        chk("bus_jump_flush", {30'd0, last_a[6:5]}, 32'd3);
        jump = 0;
        step("bus_after");
        chk("bus_memwb_cycles", n_memwb_a, 3);
        chk("bus_jump_once", {30'd0, last_a[6:5]}, 32'd0);

        // jump seen only in the first busy cycle stays pending
        busy = 1; jump = 1; step("pend_a");
        jump = 0; step("pend_b");
        busy = 0; step("pend_apply");
        chk("pend_flush", {30'd0, last_a[6:5]}, 32'd3);
        step("pend_done");

        // trap during MD_WAIT with a load-use present
        md_start = 1; step("trap_md_start");
        md_start = 0; step("trap_pre");
        trap = 1; memrd = 1; rdwe = 1; rd = 3; rs1 = 3; rs1_re = 1;
        step("trap");
        chk("trap_ctrl", {23'd0, last_a[10:2]}, {23'd0, 9'b0000_1110_0});
        clear_in();
        step("trap_after");
        chk("trap_state", {30'd0, last_a[1:0]}, 32'd0);

        // reset in the middle of MD_WAIT
        md_start = 1; step("rst_md_start");
        md_start = 0;
        repeat (3) step("rst_md_wait");
        rst = 1; step("rst_mid");
        chk("rst_mid_outputs", {21'd0, last_a}, 32'd0);
        rst = 0; step("rst_after");
        chk("rst_state", {30'd0, last_a[1:0]}, 32'd0);
        n_to_b = 0;
        md_start = 1; step("rst_md_restart");
        md_start = 0;
        repeat (8) step("rst_md_count");
        chk("rst_cnt_fresh", n_to_b, 1);
        md_done = 1; step("rst_md_release");
        clear_in();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            trap     = ($urandom_range(0, 15) == 0);
            busy     = ($urandom_range(0, 3) == 0);
            md_start = ($urandom_range(0, 3) == 0);
            md_done  = ($urandom_range(0, 5) == 0);
            jump     = ($urandom_range(0, 3) == 0);
            memrd    = 1'($urandom_range(0, 1));
            rdwe     = 1'($urandom_range(0, 1));
            rs1_re   = 1'($urandom_range(0, 1));
            rs2_re   = 1'($urandom_range(0, 1));
            rd       = 5'($urandom_range(0, 3));
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
